// File: rtl/tpu_pkg.sv
// Shared types and constants for the accelerator's host-link blocks.
// The result streamer's FSM encoding and its default frame SYNC byte live here.
package tpu_pkg;

  // Default first byte of every outbound frame.
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Result streamer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_LEN     = 3'd2,
    ST_FETCH   = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_PAYLOAD = 3'd5,
    ST_CSUM    = 3'd6,
    ST_DONE    = 3'd7
  } result_streamer_state_e;

  // True in states that present a byte to the TX FIFO.
  // CSUM is handled separately because it only exists with the checksum build.
  function automatic logic is_data_write_state(input result_streamer_state_e s);
    return (s == ST_SYNC) || (s == ST_LEN) || (s == ST_PAYLOAD);
  endfunction

endpackage

// File: rtl/frame_checksum.sv
// 8-bit XOR accumulator used for the optional frame checksum.
// load_i has priority over en_i; the accumulated value is registered.
module frame_checksum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_value_i,
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] value_o
);

  logic [W-1:0] value_q;

  // Load a seed value or fold the next byte into the running XOR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else if (load_i) begin
      value_q <= load_value_i;
    end else if (en_i) begin
      value_q <= value_q ^ data_i;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/result_streamer.sv
// Result streamer: reads a contiguous, wrapping region of the unified buffer
// and writes it to the TX FIFO as SYNC, LEN, payload[LEN] and, when the
// RESULT_STREAMER_CHECKSUM_EN macro is defined, a trailing XOR checksum byte.
// Each payload byte costs FETCH (read strobe), CAPTURE (latch read data) and
// PAYLOAD (write); every write state simply waits while the FIFO is full.
module result_streamer
  import tpu_pkg::*;
#(
  parameter int                         FIFO_DATA_WIDTH = 8,
  parameter int                         BUFFER_SIZE     = 1024,
  parameter int                         ADDRESS_SIZE    = $clog2(BUFFER_SIZE),
  parameter logic [FIFO_DATA_WIDTH-1:0] SYNC_BYTE       = SYNC_BYTE_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDRESS_SIZE-1:0]    base_addr,
  input  logic [FIFO_DATA_WIDTH-1:0] length,
  output logic                       busy,
  output logic                       done,
  output logic                       mem_re,
  output logic [ADDRESS_SIZE-1:0]    mem_addr,
  input  logic [FIFO_DATA_WIDTH-1:0] mem_rdata,
  output logic                       fifo_we,
  output logic [FIFO_DATA_WIDTH-1:0] fifo_wdata,
  input  logic                       fifo_full
);

  // One extra counter bit so a full 255-byte payload compares cleanly.
  localparam int CNT_W = FIFO_DATA_WIDTH + 1;
  localparam logic [ADDRESS_SIZE:0] BUF_DEPTH = (ADDRESS_SIZE + 1)'(BUFFER_SIZE);

  result_streamer_state_e        state_q;
  logic [ADDRESS_SIZE-1:0]       base_q;
  logic [FIFO_DATA_WIDTH-1:0]    len_q;
  logic [CNT_W-1:0]              cnt_q;
  logic [FIFO_DATA_WIDTH-1:0]    byte_q;
  logic                          busy_q;
  logic                          done_q;
  logic                          mem_re_q;
  logic [ADDRESS_SIZE-1:0]       mem_addr_q;

  logic                          wr_state_s;
  logic                          we_s;
  logic [FIFO_DATA_WIDTH-1:0]    wdata_s;
  logic [CNT_W-1:0]              cnt_inc_s;
  logic                          last_s;
  logic [ADDRESS_SIZE:0]         addr_sum_s;
  logic [ADDRESS_SIZE-1:0]       addr_next_s;

`ifdef RESULT_STREAMER_CHECKSUM_EN
  logic                          csum_load_s;
  logic [FIFO_DATA_WIDTH-1:0]    csum_load_val_s;
  logic                          csum_en_s;
  logic [FIFO_DATA_WIDTH-1:0]    csum_value_s;
`endif

  // Write qualification: a byte goes out only in a write state with FIFO room.
  always_comb begin
    wr_state_s = is_data_write_state(state_q);
`ifdef RESULT_STREAMER_CHECKSUM_EN
    if (state_q == ST_CSUM) begin
      wr_state_s = 1'b1;
    end else begin
      wr_state_s = is_data_write_state(state_q);
    end
`endif
    we_s = wr_state_s && !fifo_full;
  end

  // Byte presented to the FIFO; it depends only on registered state so it
  // stays put for as long as the FIFO holds off the write.
  always_comb begin
    wdata_s = '0;
    case (state_q)
      ST_SYNC:    wdata_s = SYNC_BYTE;
      ST_LEN:     wdata_s = len_q;
      ST_PAYLOAD: wdata_s = byte_q;
`ifdef RESULT_STREAMER_CHECKSUM_EN
      ST_CSUM:    wdata_s = csum_value_s;
`endif
      default:    wdata_s = '0;
    endcase
  end

  // Payload progress and the wrapped address of the next byte to fetch.
  always_comb begin
    cnt_inc_s  = cnt_q + CNT_W'(1);
    last_s     = (cnt_inc_s == {1'b0, len_q});
    addr_sum_s = {1'b0, base_q} + (ADDRESS_SIZE + 1)'(cnt_inc_s);
    if (addr_sum_s >= BUF_DEPTH) begin
      addr_next_s = ADDRESS_SIZE'(addr_sum_s - BUF_DEPTH);
    end else begin
      addr_next_s = ADDRESS_SIZE'(addr_sum_s);
    end
  end

`ifdef RESULT_STREAMER_CHECKSUM_EN
  // Checksum control: clear on start, seed with LEN, fold each written byte.
  always_comb begin
    csum_load_s     = 1'b0;
    csum_load_val_s = '0;
    csum_en_s       = 1'b0;
    if ((state_q == ST_IDLE) && start) begin
      csum_load_s     = 1'b1;
      csum_load_val_s = '0;
    end else if ((state_q == ST_LEN) && we_s) begin
      csum_load_s     = 1'b1;
      csum_load_val_s = len_q;
    end else if ((state_q == ST_PAYLOAD) && we_s) begin
      csum_en_s       = 1'b1;
    end else begin
      csum_load_s     = 1'b0;
    end
  end

  frame_checksum #(
    .W (FIFO_DATA_WIDTH)
  ) u_frame_checksum (
    .clk          (clk),
    .rst          (rst),
    .load_i       (csum_load_s),
    .load_value_i (csum_load_val_s),
    .en_i         (csum_en_s),
    .data_i       (byte_q),
    .value_o      (csum_value_s)
  );
`endif

  // Frame sequencer with registered status and buffer-read outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      byte_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      done_q   <= 1'b0;
      mem_re_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            len_q   <= length;
            cnt_q   <= '0;
            byte_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (we_s) begin
            state_q <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (we_s) begin
            if (len_q == '0) begin
`ifdef RESULT_STREAMER_CHECKSUM_EN
              state_q <= ST_CSUM;
`else
              done_q  <= 1'b1;
              state_q <= ST_DONE;
`endif
            end else begin
              mem_re_q   <= 1'b1;
              mem_addr_q <= base_q;
              state_q    <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          byte_q  <= mem_rdata;
          state_q <= ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          if (we_s) begin
            cnt_q <= cnt_inc_s;
            if (last_s) begin
`ifdef RESULT_STREAMER_CHECKSUM_EN
              state_q <= ST_CSUM;
`else
              done_q  <= 1'b1;
              state_q <= ST_DONE;
`endif
            end else begin
              mem_re_q   <= 1'b1;
              mem_addr_q <= addr_next_s;
              state_q    <= ST_FETCH;
            end
          end
        end
`ifdef RESULT_STREAMER_CHECKSUM_EN
        ST_CSUM: begin
          if (we_s) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mem_re     = mem_re_q;
  assign mem_addr   = mem_addr_q;
  assign fifo_we    = we_s;
  assign fifo_wdata = wdata_s;

endmodule
